mem_port_arbiter: RTL and testbench

- Shares one single-port backing memory between two requesters: the instruction fetcher (I port) and the pipeline MEM stage (D port).
- Grants one transaction at a time and tracks its fixed-latency completion.
- Returns read data and a done pulse to the owning requester; the pipeline uses the absence of gnt/done to stall IF or MEM.
- Sits between the Fetcher/MEM stage and the Memory block, replacing their private memory paths.

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_arb_timer.sv | 28 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
// Owner and state encodings used by the arbiter FSM.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        NONE,
        IFETCH,
        DATA
    } owner_t;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter tracking fixed memory latency.
// zero marks the completion cycle of a transaction.
module mem_arb_timer #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int CW = $clog2(LATENCY + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LATENCY - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (I) and MEM (D).
// D has priority; I is forced through after STARVE_LIMIT D grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cancel,
    output logic              i_gnt,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t        state;
    owner_t        owner;
    logic          we_q;
    logic          cancel_q;
    logic [SW-1:0] streak;
    logic          zero;
    logic          complete;
    logic          can_grant;
    logic          starved;
    logic          i_win;
    logic          d_win;
    logic          grant;

    mem_arb_timer #(
        .LATENCY(LATENCY)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(grant),
        .zero(zero)
    );

    assign complete  = (state == BUSY) && zero;
    // rst gate keeps the Mealy grant path quiet while reset is held
    assign can_grant = rst && ((state == IDLE) || complete);
    assign starved   = (streak == SW'(STARVE_LIMIT));
    assign i_win     = can_grant && i_req && (!d_req || starved);
    assign d_win     = can_grant && d_req && !i_win;
    assign grant     = i_win || d_win;

    assign i_gnt = i_win;
    assign d_gnt = d_win;
    assign busy  = (state == BUSY);

    always_comb begin
        mem_req   = grant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            d_win: begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            i_win: begin
                mem_addr = i_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        i_done  = 1'b0;
        i_rdata = '0;
        d_done  = 1'b0;
        d_rdata = '0;
        if (complete && owner == IFETCH && !(cancel_q || i_cancel)) begin
            i_done  = 1'b1;
            i_rdata = mem_rdata;
        end
        if (complete && owner == DATA) begin
            d_done  = 1'b1;
            d_rdata = we_q ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= NONE;
            we_q     <= 1'b0;
            cancel_q <= 1'b0;
            streak   <= '0;
        end else begin
            if (grant) begin
                state <= BUSY;
                owner <= i_win ? IFETCH : DATA;
                we_q  <= d_win && d_we;
            end else if (complete) begin
                state <= IDLE;
                owner <= NONE;
                we_q  <= 1'b0;
            end

            if (complete) begin
                cancel_q <= 1'b0;
            end else if (state == BUSY && owner == IFETCH && i_cancel) begin
                cancel_q <= 1'b1;
            end

            if (!i_req || i_win) begin
                streak <= '0;
            end else if (d_win && !starved) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle memory model.
// Cycle k starts 1ns after posedge k; outputs are sampled at negedge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_cancel;
    logic        i_gnt;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks;
    int errors;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] p0;
    logic [31:0] p1;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .LATENCY     (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_cancel (i_cancel),
        .i_gnt    (i_gnt),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // memory: read data appears two cycles after the request cycle
    always @(posedge clk) begin
        p1 <= p0;
        p0 <= (mem_req && !mem_we) ? mem_rd(mem_addr) : 32'h0;
        if (mem_req && mem_we) mem[mem_addr] = mem_wdata;
    end
    assign mem_rdata = p1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_in();
        i_req    = 1'b0;
        i_addr   = 32'h0;
        i_cancel = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
    endtask

    logic [10:0] d_tab;
    logic [10:0] i_tab;
    logic [10:0] dd_tab;
    logic [10:0] id_tab;

    initial begin
        checks = 0;
        errors = 0;
        p0 = 32'h0;
        p1 = 32'h0;
        mem[32'h40] = 32'h2002_0005;
        mem[32'h44] = 32'h3333_4444;
        mem[32'h48] = 32'h1111_2222;
        d_tab  = 11'b10001010101;
        i_tab  = 11'b00100000000;
        dd_tab = 11'b00101010100;
        id_tab = 11'b10000000000;

        // reset: requests held high, every output must stay low
        clear_in();
        rst   = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        tick();
        sample();
        check("rst_i_gnt", {31'h0, i_gnt}, 32'h0);
        check("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        tick();
        clear_in();
        rst = 1'b1;
        tick();

        // lone fetch
        i_req  = 1'b1;
        i_addr = 32'h40;
        sample();
        check("lf_i_gnt", {31'h0, i_gnt}, 32'h1);
        check("lf_mem_req", {31'h0, mem_req}, 32'h1);
        check("lf_mem_addr", mem_addr, 32'h40);
        check("lf_mem_we", {31'h0, mem_we}, 32'h0);
        tick();
        clear_in();
        sample();
        check("lf_busy1", {31'h0, busy}, 32'h1);
        check("lf_i_done1", {31'h0, i_done}, 32'h0);
        tick();
        sample();
        check("lf_i_done2", {31'h0, i_done}, 32'h1);
        check("lf_i_rdata", i_rdata, 32'h2002_0005);
        check("lf_busy2", {31'h0, busy}, 32'h1);
        tick();
        sample();
        check("lf_busy3", {31'h0, busy}, 32'h0);
        check("lf_i_rdata3", i_rdata, 32'h0);
        tick();

        // contention: D four times, then I, then D
        i_req  = 1'b1;
        i_addr = 32'h44;
        d_req  = 1'b1;
        d_addr = 32'h200;
        for (int k = 0; k <= 10; k++) begin
            sample();
            check($sformatf("ct_d_gnt%0d", k), {31'h0, d_gnt}, {31'h0, d_tab[k]});
            check($sformatf("ct_i_gnt%0d", k), {31'h0, i_gnt}, {31'h0, i_tab[k]});
            check($sformatf("ct_d_done%0d", k), {31'h0, d_done}, {31'h0, dd_tab[k]});
            check($sformatf("ct_i_done%0d", k), {31'h0, i_done}, {31'h0, id_tab[k]});
            if (k == 10) check("ct_i_rdata", i_rdata, 32'h3333_4444);
            tick();
        end
        clear_in();
        for (int k = 0; k < 3; k++) tick();

        // write then back-to-back read of the same address
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        sample();
        check("wr_d_gnt", {31'h0, d_gnt}, 32'h1);
        check("wr_mem_we", {31'h0, mem_we}, 32'h1);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        clear_in();
        tick();
        d_req  = 1'b1;
        d_addr = 32'h100;
        sample();
        check("wr_d_done", {31'h0, d_done}, 32'h1);
        check("wr_d_rdata", d_rdata, 32'h0);
        check("rd_d_gnt", {31'h0, d_gnt}, 32'h1);
        check("rd_mem_we", {31'h0, mem_we}, 32'h0);
        tick();
        clear_in();
        tick();
        sample();
        check("rd_d_done", {31'h0, d_done}, 32'h1);
        check("rd_d_rdata", d_rdata, 32'hDEAD_BEEF);
        tick();
        sample();
        check("rd_busy_end", {31'h0, busy}, 32'h0);
        tick();

        // cancel without follow-up
        i_req  = 1'b1;
        i_addr = 32'h40;
        sample();
        check("ca_i_gnt", {31'h0, i_gnt}, 32'h1);
        tick();
        clear_in();
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        sample();
        check("ca_i_done", {31'h0, i_done}, 32'h0);
        check("ca_busy2", {31'h0, busy}, 32'h1);
        tick();
        sample();
        check("ca_busy3", {31'h0, busy}, 32'h0);
        tick();

        // cancel with a new fetch granted in the completion cycle
        i_req  = 1'b1;
        i_addr = 32'h40;
        tick();
        clear_in();
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
        i_req    = 1'b1;
        i_addr   = 32'h48;
        sample();
        check("cb_i_done2", {31'h0, i_done}, 32'h0);
        check("cb_i_gnt2", {31'h0, i_gnt}, 32'h1);
        tick();
        clear_in();
        sample();
        check("cb_busy3", {31'h0, busy}, 32'h1);
        tick();
        sample();
        check("cb_i_done4", {31'h0, i_done}, 32'h1);
        check("cb_i_rdata4", i_rdata, 32'h1111_2222);
        tick();
        sample();
        check("cb_busy5", {31'h0, busy}, 32'h0);
        tick();

        // reset mid-transaction
        d_req  = 1'b1;
        d_addr = 32'h100;
        sample();
        check("rs_d_gnt", {31'h0, d_gnt}, 32'h1);
        tick();
        clear_in();
        i_req = 1'b1;
        rst   = 1'b0;
        sample();
        check("rs_busy", {31'h0, busy}, 32'h0);
        check("rs_i_gnt", {31'h0, i_gnt}, 32'h0);
        check("rs_mem_req", {31'h0, mem_req}, 32'h0);
        tick();
        clear_in();
        rst = 1'b1;
        sample();
        check("rs_d_done", {31'h0, d_done}, 32'h0);
        check("rs_d_rdata", d_rdata, 32'h0);
        tick();
        d_req  = 1'b1;
        d_addr = 32'h100;
        sample();
        check("rs_regnt", {31'h0, d_gnt}, 32'h1);
        tick();
        clear_in();
        tick();
        sample();
        check("rs_redone", {31'h0, d_done}, 32'h1);
        check("rs_rerdata", d_rdata, 32'hDEAD_BEEF);
        tick();
        tick();

        // withdraw: D request dropped while the port is busy
        i_req  = 1'b1;
        i_addr = 32'h40;
        tick();
        clear_in();
        d_req  = 1'b1;
        d_addr = 32'h300;
        sample();
        check("wd_d_gnt1", {31'h0, d_gnt}, 32'h0);
        check("wd_mem_req1", {31'h0, mem_req}, 32'h0);
        tick();
        clear_in();
        i_req  = 1'b1;
        i_addr = 32'h44;
        sample();
        check("wd_d_gnt2", {31'h0, d_gnt}, 32'h0);
        check("wd_i_gnt2", {31'h0, i_gnt}, 32'h1);
        check("wd_mem_addr2", mem_addr, 32'h44);
        tick();
        clear_in();
        sample();
        check("wd_mem_req3", {31'h0, mem_req}, 32'h0);
        tick();
        sample();
        check("wd_i_done4", {31'h0, i_done}, 32'h1);
        check("wd_d_done4", {31'h0, d_done}, 32'h0);
        tick();
        sample();
        check("wd_busy5", {31'h0, busy}, 32'h0);
        check("wd_d_done5", {31'h0, d_done}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
